// File: rtl/nibble_serial_adder_if.sv
// Bus between the nibble-serial add controller, its requester and the external
// 4-bit full adder (fourBitFA). The master side is the requester plus the adder.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  logic                   Start;
  logic [4*NIBBLES-1:0]   OpA;
  logic [4*NIBBLES-1:0]   OpB;
  logic                   CarryInit;
  logic [3:0]             FaINa;
  logic [3:0]             FaINb;
  logic                   FaCarryIn;
  logic [3:0]             FaSum;
  logic                   FaCarryOut;
  logic [4*NIBBLES-1:0]   Result;
  logic                   CarryOut;
  logic                   Busy;
  logic                   Done;

  modport master (
    output Start, OpA, OpB, CarryInit, FaSum, FaCarryOut,
    input  FaINa, FaINb, FaCarryIn, Result, CarryOut, Busy, Done
  );

  modport slave (
    input  Start, OpA, OpB, CarryInit, FaSum, FaCarryOut,
    output FaINa, FaINb, FaCarryIn, Result, CarryOut, Busy, Done
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Adds two NIBBLES-wide unsigned operands one nibble per clock through an
// external combinational 4-bit full adder, rippling carry through a register.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                  Clk,
  input  logic                  RstN,
  nibble_serial_adder_if.slave  bus
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state_q;
  state_t                      state_d;
  logic [NIBBLES-1:0][3:0]     a_q;
  logic [NIBBLES-1:0][3:0]     b_q;
  logic [NIBBLES-1:0][3:0]     result_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        carry_q;
  logic                        cout_q;
  logic                        busy;
  logic                        done;
  logic [3:0]                  fa_a;
  logic [3:0]                  fa_b;
  logic                        fa_c;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (bus.Start) state_d = ADD;
      ADD: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Adder operands are driven only while adding so the shared adder sees zeros otherwise.
  always_comb begin
    fa_a = 4'd0;
    fa_b = 4'd0;
    fa_c = 1'b0;
    if (state_q == ADD) begin
      fa_c = carry_q;
      for (int k = 0; k < NIBBLES; k++) begin
        if (idx_q == k[IDX_W-1:0]) begin
          fa_a = a_q[k];
          fa_b = b_q[k];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else if (state_q == IDLE && bus.Start) begin
      a_q      <= bus.OpA;
      b_q      <= bus.OpB;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= bus.CarryInit;
      cout_q   <= 1'b0;
    end else if (state_q == ADD) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (idx_q == k[IDX_W-1:0]) result_q[k] <= bus.FaSum;
      end
      carry_q <= bus.FaCarryOut;
      idx_q   <= idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) cout_q <= bus.FaCarryOut;
    end
  end

  assign bus.FaINa     = fa_a;
  assign bus.FaINb     = fa_b;
  assign bus.FaCarryIn = fa_c;
  assign bus.Result    = result_q;
  assign bus.CarryOut  = cout_q;
  assign bus.Busy      = busy;
  assign bus.Done      = done;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 4-nibble and a 1-nibble instance,
// each wired to a behavioural 4-bit full adder.
module tb_nibble_serial_adder;

  logic Clk;
  logic RstN;
  int   n_cmp;
  int   n_bad;

  nibble_serial_adder_if #(.NIBBLES(4)) if4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) if1 ();

  nibble_serial_adder #(.NIBBLES(4)) dut4 (.Clk(Clk), .RstN(RstN), .bus(if4.slave));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.Clk(Clk), .RstN(RstN), .bus(if1.slave));

  // Stand-in for the external fourBitFA.
  assign {if4.FaCarryOut, if4.FaSum} = {1'b0, if4.FaINa} + {1'b0, if4.FaINb} + {4'b0, if4.FaCarryIn};
  assign {if1.FaCarryOut, if1.FaSum} = {1'b0, if1.FaINa} + {1'b0, if1.FaINb} + {4'b0, if1.FaCarryIn};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Launches one run on the 4-nibble instance and records what it observes.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      output logic [15:0] sa, output logic [15:0] sb, output logic [3:0] sc,
                      output logic [15:0] res, output logic co,
                      output int done_edge, output int done_cnt, output int busy_cnt);
    int n;
    n = 0; sa = '0; sb = '0; sc = '0; res = 'x; co = 1'bx;
    done_edge = -1; done_cnt = 0; busy_cnt = 0;
    if4.OpA = a; if4.OpB = b; if4.CarryInit = cin; if4.Start = 1'b1;
    @(posedge Clk); #1;
    if4.Start = 1'b0;
    for (int e = 0; e < 10; e++) begin
      if (if4.Busy) busy_cnt++;
      if (if4.Busy && !if4.Done && n < 4) begin
        sa[4*n +: 4] = if4.FaINa;
        sb[4*n +: 4] = if4.FaINb;
        sc[n]        = if4.FaCarryIn;
        n++;
      end
      if (if4.Done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          res = if4.Result;
          co  = if4.CarryOut;
        end
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      output logic [3:0] res, output logic co, output int done_edge);
    res = 'x; co = 1'bx; done_edge = -1;
    if1.OpA = a; if1.OpB = b; if1.CarryInit = cin; if1.Start = 1'b1;
    @(posedge Clk); #1;
    if1.Start = 1'b0;
    for (int e = 0; e < 3; e++) begin
      if (if1.Done && done_edge < 0) begin
        done_edge = e;
        res = if1.Result;
        co  = if1.CarryOut;
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset();
    RstN = 1'b0;
    if4.Start = 1'b0; if4.OpA = '0; if4.OpB = '0; if4.CarryInit = 1'b0;
    if1.Start = 1'b0; if1.OpA = '0; if1.OpB = '0; if1.CarryInit = 1'b0;
    #2;
    n_cmp++;
    if ({if4.Result, if4.CarryOut, if4.Busy, if4.Done} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {if4.Result, if4.CarryOut, if4.Busy, if4.Done});
    end
    n_cmp++;
    if ({if4.FaINa, if4.FaINb, if4.FaCarryIn} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_fa: got %h required 0", {if4.FaINa, if4.FaINb, if4.FaCarryIn});
    end
    n_cmp++;
    if ({if1.Result, if1.CarryOut, if1.Busy, if1.Done} !== 7'd0) begin
      n_bad++;
      $display("FAIL reset_n1: got %h required 0", {if1.Result, if1.CarryOut, if1.Busy, if1.Done});
    end
    @(negedge Clk); RstN = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_zero();
    logic [15:0] sa, sb, res; logic [3:0] sc; logic co; int de, dc, bc;
    run4(16'h0000, 16'h0000, 1'b0, sa, sb, sc, res, co, de, dc, bc);
    n_cmp++;
    if (de !== 4) begin n_bad++; $display("FAIL zero_done_edge: got %0d required 4", de); end
    n_cmp++;
    if (dc !== 1) begin n_bad++; $display("FAIL zero_done_count: got %0d required 1", dc); end
    n_cmp++;
    if (bc !== 5) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d required 5", bc); end
    n_cmp++;
    if ({res, co} !== 17'h0) begin n_bad++; $display("FAIL zero_result: got %h required 0", {res, co}); end
  endtask

  task automatic test_sequence();
    logic [15:0] sa, sb, res; logic [3:0] sc; logic co; int de, dc, bc;
    run4(16'h1234, 16'h4321, 1'b1, sa, sb, sc, res, co, de, dc, bc);
    n_cmp++;
    if (sa !== 16'h1234) begin n_bad++; $display("FAIL seq_fa_ina: got %h required 1234 (steps 4,3,2,1)", sa); end
    n_cmp++;
    if (sb !== 16'h4321) begin n_bad++; $display("FAIL seq_fa_inb: got %h required 4321 (steps 1,2,3,4)", sb); end
    n_cmp++;
    if (sc !== 4'b0001) begin n_bad++; $display("FAIL seq_fa_cin: got %b required 0001", sc); end
    n_cmp++;
    if (res !== 16'h5556 || co !== 1'b0) begin
      n_bad++; $display("FAIL seq_result: got %h/%b required 5556/0", res, co);
    end
  endtask

  task automatic test_ripple();
    logic [15:0] sa, sb, res; logic [3:0] sc; logic co; int de, dc, bc;
    run4(16'hFFFF, 16'h0001, 1'b0, sa, sb, sc, res, co, de, dc, bc);
    n_cmp++;
    if (sc !== 4'b1110) begin n_bad++; $display("FAIL ripple_fa_cin: got %b required 1110", sc); end
    n_cmp++;
    if (res !== 16'h0000 || co !== 1'b1) begin
      n_bad++; $display("FAIL ripple_result: got %h/%b required 0000/1", res, co);
    end
    n_cmp++;
    if (de !== 4) begin n_bad++; $display("FAIL ripple_done_edge: got %0d required 4", de); end
  endtask

  task automatic test_start_ignored();
    logic [15:0] res; logic co; int dc, de;
    dc = 0; de = -1; res = 'x; co = 1'bx;
    if4.OpA = 16'h0102; if4.OpB = 16'h0304; if4.CarryInit = 1'b0; if4.Start = 1'b1;
    @(posedge Clk); #1;
    if4.Start = 1'b0;
    for (int e = 0; e < 12; e++) begin
      if (e == 1) begin if4.Start = 1'b1; if4.OpA = 16'hFFFF; if4.OpB = 16'hFFFF; end
      if (e == 2) if4.Start = 1'b0;
      if (if4.Done) begin
        dc++;
        if (de < 0) begin de = e; res = if4.Result; co = if4.CarryOut; end
      end
      @(posedge Clk); #1;
    end
    n_cmp++;
    if (dc !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d required 1", dc); end
    n_cmp++;
    if (de !== 4) begin n_bad++; $display("FAIL ignore_done_edge: got %0d required 4", de); end
    n_cmp++;
    if (res !== 16'h0406 || co !== 1'b0) begin
      n_bad++; $display("FAIL ignore_result: got %h/%b required 0406/0", res, co);
    end
  endtask

  task automatic test_back_to_back();
    int edges[4]; int dc;
    dc = 0;
    for (int i = 0; i < 4; i++) edges[i] = -1;
    if4.OpA = 16'h0001; if4.OpB = 16'h0001; if4.CarryInit = 1'b0; if4.Start = 1'b1;
    @(posedge Clk); #1;
    for (int e = 0; e < 20; e++) begin
      if (if4.Done) begin
        if (dc < 4) edges[dc] = e;
        dc++;
      end
      @(posedge Clk); #1;
    end
    if4.Start = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    n_cmp++;
    if (dc !== 3) begin n_bad++; $display("FAIL held_done_count: got %0d required 3", dc); end
    n_cmp++;
    if (edges[0] !== 4 || edges[1] !== 10 || edges[2] !== 16) begin
      n_bad++;
      $display("FAIL held_done_edges: got %0d,%0d,%0d required 4,10,16", edges[0], edges[1], edges[2]);
    end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] sa, sb, res; logic [3:0] sc; logic co; int de, dc, bc, dcnt, bcnt;
    if4.OpA = 16'h1111; if4.OpB = 16'h2222; if4.CarryInit = 1'b0; if4.Start = 1'b1;
    @(posedge Clk); #1;
    if4.Start = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    RstN = 1'b0;
    #1;
    n_cmp++;
    if ({if4.Result, if4.CarryOut, if4.Busy, if4.Done} !== 19'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %h required 0", {if4.Result, if4.CarryOut, if4.Busy, if4.Done});
    end
    n_cmp++;
    if ({if4.FaINa, if4.FaINb, if4.FaCarryIn} !== 9'd0) begin
      n_bad++;
      $display("FAIL midrst_fa: got %h required 0", {if4.FaINa, if4.FaINb, if4.FaCarryIn});
    end
    #2;
    RstN = 1'b1;
    dcnt = 0; bcnt = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge Clk); #1;
      if (if4.Done) dcnt++;
      if (if4.Busy) bcnt++;
    end
    n_cmp++;
    if (dcnt !== 0 || bcnt !== 0) begin
      n_bad++; $display("FAIL midrst_no_done: got done=%0d busy=%0d required 0/0", dcnt, bcnt);
    end
    run4(16'h00FF, 16'h0001, 1'b0, sa, sb, sc, res, co, de, dc, bc);
    n_cmp++;
    if (res !== 16'h0100 || co !== 1'b0 || de !== 4) begin
      n_bad++; $display("FAIL midrst_rerun: got %h/%b edge %0d required 0100/0 edge 4", res, co, de);
    end
  endtask

  task automatic test_n1();
    logic [3:0] res; logic co; int de; logic [4:0] exp5; int bad_sweep;
    run1(4'hF, 4'hF, 1'b1, res, co, de);
    n_cmp++;
    if (de !== 1) begin n_bad++; $display("FAIL n1_done_edge: got %0d required 1", de); end
    n_cmp++;
    if (res !== 4'hF || co !== 1'b1) begin
      n_bad++; $display("FAIL n1_ff_result: got %h/%b required F/1", res, co);
    end
    bad_sweep = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp5 = 5'(a + b + c);
          run1(4'(a), 4'(b), 1'(c), res, co, de);
          n_cmp++;
          if ({co, res} !== exp5) begin
            n_bad++;
            if (bad_sweep < 20)
              $display("FAIL n1_sweep a=%h b=%h c=%0d: got %h required %h", a[3:0], b[3:0], c, {co, res}, exp5);
            bad_sweep++;
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_zero();
    test_sequence();
    test_ripple();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_n1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
